// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
//
// Receive-side deframer for the APB UART. The serial input is oversampled at
// OVS ticks per bit. Each frame's start, data, optional parity and stop bits
// are checked, and one 12-bit status+data word is written into the RX FIFO per
// received frame.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : the PARITY state and parity checking are built.
//   undefined : parity_en_i/parity_odd_i are ignored, rx_data_o[8] is 0, and
//               break detection looks at the data bits only.
//
// Ports
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   baud_tick_i   oversample enable, one clk_i wide, OVS pulses per bit time
//   rx_i          asynchronous serial line, idle high
//   data_bits_i   00=5, 01=6, 10=7, 11=8 data bits
//   stop_bits_i   0 = one stop bit, 1 = two stop bits
//   parity_en_i   parity bit present
//   parity_odd_i  1 = odd parity, 0 = even parity
//   rx_full_i     RX FIFO full
//   rx_wr_o       FIFO write strobe, one clk_i wide
//   rx_data_o     [7:0] data, [8] parity err, [9] framing err, [10] break,
//                 [11] overrun
//   busy_o        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_deframer #(
    parameter int unsigned OVS = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        baud_tick_i,
    input  logic        rx_i,
    input  logic [1:0]  data_bits_i,
    input  logic        stop_bits_i,
    input  logic        parity_en_i,
    input  logic        parity_odd_i,
    input  logic        rx_full_i,
    output logic        rx_wr_o,
    output logic [11:0] rx_data_o,
    output logic        busy_o
);

    localparam int unsigned CW = $clog2(OVS);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t r_state, w_state_nxt;

    logic          r_rx_meta, r_rx_sync;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [1:0]    r_dbits;
    logic          r_two_stop;
    logic          r_stop_idx;
    logic          r_frm_err;
    logic          r_ovr_pend;
    logic          r_rx_wr;
    logic [11:0]   r_rx_data;

    logic w_half, w_full, w_last_bit;
    logic w_cnt_clr, w_start_det, w_data_smp, w_par_smp, w_stop_smp, w_final;
    logic w_par_en, w_par_bit, w_par_err;
    logic w_frm, w_brk;

    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value; blocking here would collapse
            // the two synchronizer stages into one.
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_half     = (r_cnt == HALF_M1);
    assign w_full     = (r_cnt == FULL_M1);
    assign w_last_bit = (r_bit_cnt == (3'd4 + {1'b0, r_dbits}));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state and sample-enable decode. Everything here is qualified by
    // baud_tick_i, so all state and counter updates happen on tick edges.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_start_det = 1'b0;
        w_data_smp  = 1'b0;
        w_par_smp   = 1'b0;
        w_stop_smp  = 1'b0;
        w_final     = 1'b0;
        if (baud_tick_i) begin
            unique case (r_state)
                S_IDLE: begin
                    w_cnt_clr = 1'b1;
                    if (!r_rx_sync) begin
                        w_start_det = 1'b1;
                        w_state_nxt = S_START;
                    end
                end
                S_START: begin
                    if (w_half) begin
                        w_cnt_clr   = 1'b1;
                        // A high line at mid-bit means the start was a glitch.
                        w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_full) begin
                        w_cnt_clr  = 1'b1;
                        w_data_smp = 1'b1;
                        if (w_last_bit) w_state_nxt = w_par_en ? S_PARITY : S_STOP;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_full) begin
                        w_cnt_clr   = 1'b1;
                        w_par_smp   = 1'b1;
                        w_state_nxt = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_full) begin
                        w_cnt_clr  = 1'b1;
                        w_stop_smp = 1'b1;
                        if (!(r_two_stop && !r_stop_idx)) begin
                            w_final     = 1'b1;
                            w_state_nxt = r_rx_sync ? S_IDLE : S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    w_cnt_clr = 1'b1;
                    if (r_rx_sync) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_en, r_par_odd, r_par_bit, r_par_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_par_bit <= 1'b0;
            r_par_err <= 1'b0;
        end else if (w_start_det) begin
            r_par_en  <= parity_en_i;
            r_par_odd <= parity_odd_i;
            r_par_bit <= 1'b0;
            r_par_err <= 1'b0;
        end else if (w_par_smp) begin
            r_par_bit <= r_rx_sync;
            // Unused upper shift bits are zero, so the XOR covers only the
            // received data bits.
            r_par_err <= (^r_shift) ^ r_rx_sync ^ r_par_odd;
        end
    end

    assign w_par_en  = r_par_en;
    assign w_par_bit = r_par_bit;
    assign w_par_err = r_par_err;
`else
    logic w_unused_par;
    assign w_unused_par = parity_en_i ^ parity_odd_i ^ w_par_smp;
    assign w_par_en     = 1'b0;
    assign w_par_bit    = 1'b0;
    assign w_par_err    = 1'b0;
`endif

    // Status of the frame as seen at the final stop sample.
    assign w_frm = r_frm_err | ~r_rx_sync;
    assign w_brk = w_frm & (r_shift == 8'h00) & ~w_par_bit;

    // Datapath: tick counter, frame configuration, shift register, stop
    // checking, and the FIFO write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_dbits    <= '0;
            r_two_stop <= 1'b0;
            r_stop_idx <= 1'b0;
            r_frm_err  <= 1'b0;
            r_ovr_pend <= 1'b0;
            r_rx_wr    <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_wr <= 1'b0;

            if (baud_tick_i) r_cnt <= w_cnt_clr ? '0 : r_cnt + CW'(1);

            if (w_start_det) begin
                r_dbits    <= data_bits_i;
                r_two_stop <= stop_bits_i;
                r_bit_cnt  <= '0;
                r_shift    <= '0;
                r_stop_idx <= 1'b0;
                r_frm_err  <= 1'b0;
            end

            if (w_data_smp) begin
                r_shift[r_bit_cnt] <= r_rx_sync;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
            end

            if (w_stop_smp) begin
                r_stop_idx <= 1'b1;
                if (!r_rx_sync) r_frm_err <= 1'b1;
            end

            // The write strobe lands on the clk_i cycle after the final stop
            // sample; a full FIFO drops the frame and flags the next write.
            if (w_final) begin
                if (!rx_full_i) begin
                    r_rx_wr    <= 1'b1;
                    r_rx_data  <= {r_ovr_pend, w_brk, w_frm, w_par_err, r_shift};
                    r_ovr_pend <= 1'b0;
                end else begin
                    r_ovr_pend <= 1'b1;
                end
            end
        end
    end

    assign rx_wr_o   = r_rx_wr;
    assign rx_data_o = r_rx_data;
    assign busy_o    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deframer
//
// Self-checking bench for uart_rx_deframer at OVS=16. Every frame sent pushes
// its expected status word into a queue; a monitor pops and compares on each
// rx_wr_o. Directed checks cover reset, busy_o, glitches, break, overrun and
// reset during a frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx_deframer;

    localparam int OVS      = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = OVS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        baud_tick_i = 1'b0;
    logic        rx_i = 1'b1;
    logic [1:0]  data_bits_i = 2'b11;
    logic        stop_bits_i = 1'b0;
    logic        parity_en_i = 1'b0;
    logic        parity_odd_i = 1'b0;
    logic        rx_full_i = 1'b0;
    logic        rx_wr_o;
    logic [11:0] rx_data_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    logic [11:0] exp_q[$];

    uart_rx_deframer #(.OVS(OVS)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .baud_tick_i  (baud_tick_i),
        .rx_i         (rx_i),
        .data_bits_i  (data_bits_i),
        .stop_bits_i  (stop_bits_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .rx_full_i    (rx_full_i),
        .rx_wr_o      (rx_wr_o),
        .rx_data_o    (rx_data_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // One-clock baud tick every TICK_DIV clocks, changed just after the edge.
    initial begin
        int k = 0;
        forever begin
            @(posedge clk_i);
            #1;
            k++;
            baud_tick_i = (k % TICK_DIV == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (rx_wr_o) begin
            n_wr++;
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rx_data", 32'(rx_data_o), 32'(exp_q.pop_front()));
        end
    end

    // Reference word for a frame as it appears on the line.
    function automatic logic [11:0] model(input logic [7:0] d, input int nbits,
                                          input bit par_on, input bit odd,
                                          input logic pbit, input bit stop_ok,
                                          input bit ovr);
        logic [8:0] mask;
        logic [7:0] dm;
        logic perr, frm, brk;
        mask = (9'd1 << nbits) - 9'd1;
        dm   = d & mask[7:0];
        perr = par_on ? ((^dm) ^ pbit ^ odd) : 1'b0;
        frm  = !stop_ok;
        brk  = frm && (dm == 8'h00) && !(par_on && pbit);
        return {ovr, brk, frm, perr, dm};
    endfunction

    task automatic drive(input logic v, input int nclk);
        rx_i = v;
        repeat (nclk) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit with_par,
                              input logic pbit, input int nstop, input logic [1:0] stops);
        drive(1'b0, BIT_CLK);
        for (int i = 0; i < nbits; i++) drive(d[i], BIT_CLK);
        if (with_par) drive(pbit, BIT_CLK);
        drive(stops[0], BIT_CLK);
        if (nstop == 2) drive(stops[1], BIT_CLK);
    endtask

    task automatic drain(input string tag);
        int budget = 4 * BIT_CLK;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk_i);
            budget--;
        end
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int wr0;
        logic [11:0] e;

        repeat (5) @(posedge clk_i);
        #1;
        check("reset_wr", 32'(rx_wr_o), 32'd0);
        check("reset_data", 32'(rx_data_o), 32'h000);
        check("reset_busy", 32'(busy_o), 32'd0);
        rst_ni = 1'b1;
        drive(1'b1, BIT_CLK);

        // 8N1 0xA5, with busy_o observed mid-frame and after the stop bit.
        wr0 = n_wr;
        exp_q.push_back(model(8'hA5, 8, 0, 0, 0, 1, 0));
        drive(1'b0, BIT_CLK);
        check("busy_mid_frame", 32'(busy_o), 32'd1);
        for (int i = 0; i < 8; i++) drive(logic'((8'hA5 >> i) & 8'h01), BIT_CLK);
        drive(1'b1, BIT_CLK);
        check("busy_after_stop", 32'(busy_o), 32'd0);
        drain("drain_a5");
        check("wr_count_a5", 32'(n_wr - wr0), 32'd1);

        // 7 data bits, even parity, wrong parity bit.
        data_bits_i = 2'b10; parity_en_i = 1'b1; parity_odd_i = 1'b0;
        e = PAR_BUILT ? model(8'h41, 7, 1, 0, 1'b1, 1, 0) : model(8'h41, 7, 0, 0, 1'b0, 1, 0);
        exp_q.push_back(e);
        send_frame(8'h41, 7, 1, 1'b1, 1, 2'b11);
        drain("drain_7e_bad");

        // 8 data bits, odd parity, correct parity bit.
        data_bits_i = 2'b11; parity_odd_i = 1'b1;
        e = PAR_BUILT ? model(8'h22, 8, 1, 1, 1'b1, 1, 0) : model(8'h22, 8, 0, 0, 1'b0, 1, 0);
        exp_q.push_back(e);
        send_frame(8'h22, 8, 1, 1'b1, 1, 2'b11);
        drain("drain_8o_ok");
        parity_en_i = 1'b0; parity_odd_i = 1'b0;

        // 5 data bits (smallest width); upper data bits must come out zero.
        data_bits_i = 2'b00;
        exp_q.push_back(model(8'hFF, 5, 0, 0, 0, 1, 0));
        send_frame(8'hFF, 5, 0, 1'b0, 1, 2'b11);
        drive(1'b1, BIT_CLK);
        drain("drain_5n1");
        data_bits_i = 2'b11;

        // Two stop bits, second one low: framing error, then back high.
        stop_bits_i = 1'b1;
        exp_q.push_back(model(8'h81, 8, 0, 0, 0, 0, 0));
        send_frame(8'h81, 8, 0, 1'b0, 2, 2'b01);
        drain("drain_8n2_bad");
        check("busy_wait_high_2stop", 32'(busy_o), 32'd1);
        drive(1'b1, BIT_CLK);
        check("busy_idle_2stop", 32'(busy_o), 32'd0);
        stop_bits_i = 1'b0;

        // 8N1 0x3C with the stop bit low for a bit time: WAIT_HIGH, then IDLE.
        exp_q.push_back(model(8'h3C, 8, 0, 0, 0, 0, 0));
        send_frame(8'h3C, 8, 0, 1'b0, 1, 2'b00);
        drain("drain_3c");
        check("busy_wait_high", 32'(busy_o), 32'd1);
        drive(1'b1, BIT_CLK);
        check("busy_idle_after_high", 32'(busy_o), 32'd0);

        // Line held low for two frame times: one break write only.
        wr0 = n_wr;
        exp_q.push_back(model(8'h00, 8, 0, 0, 0, 0, 0));
        drive(1'b0, 20 * BIT_CLK);
        drain("drain_break");
        check("break_single_wr", 32'(n_wr - wr0), 32'd1);
        check("break_busy_low_line", 32'(busy_o), 32'd1);
        drive(1'b1, 2 * BIT_CLK);
        check("break_busy_released", 32'(busy_o), 32'd0);
        check("break_no_extra_wr", 32'(n_wr - wr0), 32'd1);

        // Four-tick low glitch on an idle line: false start, no write.
        wr0 = n_wr;
        drive(1'b0, 4 * TICK_DIV);
        drive(1'b1, 2 * BIT_CLK);
        check("glitch_no_wr", 32'(n_wr - wr0), 32'd0);
        check("glitch_idle", 32'(busy_o), 32'd0);
        check("data_hold", 32'(rx_data_o), 32'h600);

        // Overrun: frame 0x11 dropped while full, 0x22 carries the flag.
        wr0 = n_wr;
        rx_full_i = 1'b1;
        send_frame(8'h11, 8, 0, 1'b0, 1, 2'b11);
        rx_full_i = 1'b0;
        drive(1'b1, BIT_CLK);
        exp_q.push_back(model(8'h22, 8, 0, 0, 0, 1, 1));
        send_frame(8'h22, 8, 0, 1'b0, 1, 2'b11);
        drain("drain_overrun");
        check("overrun_wr_count", 32'(n_wr - wr0), 32'd1);
        drive(1'b1, BIT_CLK);

        // Reset in the middle of DATA, then a clean frame.
        wr0 = n_wr;
        drive(1'b0, BIT_CLK);
        drive(1'b1, BIT_CLK);
        drive(1'b0, BIT_CLK);
        drive(1'b1, BIT_CLK / 2);
        rst_ni = 1'b0;
        #2;
        check("midrst_data", 32'(rx_data_o), 32'h000);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_wr", 32'(rx_wr_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        drive(1'b1, 2 * BIT_CLK);
        check("midrst_no_wr", 32'(n_wr - wr0), 32'd0);
        exp_q.push_back(model(8'h5A, 8, 0, 0, 0, 1, 0));
        send_frame(8'h5A, 8, 0, 1'b0, 1, 2'b11);
        drive(1'b1, BIT_CLK);
        drain("drain_5a");
        check("final_busy", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Receive-side deframer for the APB UART. Oversamples the serial input at 16x the baud rate, validates start, data, optional parity and stop bits, and writes one 12-bit status-plus-data word into the RX FIFO per received frame. It is the receive counterpart of the TX path, which shifts 12-bit FIFO words out on the baud tick.

## Interface
Parameters:
- OVS, 16, oversample ticks per bit; must be an even value of at least 8.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- baud_tick_i  in  1  oversample enable, one clk_i wide, OVS pulses per bit time.
- rx_i  in  1  serial line, idle high; asynchronous, synchronized internally by 2 flops.
- data_bits_i  in  2  00=5, 01=6, 10=7, 11=8 data bits.
- stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits.
- parity_en_i  in  1  parity bit present (see Configuration).
- parity_odd_i  in  1  1 = odd parity, 0 = even parity.
- rx_full_i  in  1  RX FIFO full.
- rx_wr_o  out  1  FIFO write strobe, one clk_i wide.
- rx_data_o  out  12  [7:0] data, LSB-aligned and zero-extended; [8] parity error; [9] framing error; [10] break; [11] overrun.
- busy_o  out  1  high in every state except IDLE.

## Operation
- Configuration inputs are sampled when a start is detected and held for the whole frame. Changes mid-frame have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. All state and counter updates occur only on clk_i edges where baud_tick_i=1. The one exception is the write strobe, described below.
- IDLE: when the synchronized rx is 0 on a tick, clear the tick counter and go to START.
- START: at tick count OVS/2-1 (mid-bit), sample rx.
  - rx=1: false start; return to IDLE, no write.
  - rx=0: clear the counter and go to DATA.
- DATA: sample rx when the counter reaches OVS-1, then clear the counter.
  - Bits are received LSB first into a shift register.
  - After N bits, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: sample at OVS-1. Error bit = XOR(data bits, parity bit, parity_odd_i).
- STOP: sample at OVS-1.
  - rx=0 on any stop bit sets the framing error.
  - With stop_bits_i=1, a second stop bit is sampled OVS ticks later.
  - If the frame is a framing error with all data bits 0 and the parity bit (if present) 0, break is also set.
- End of frame: on the clk_i cycle after the final stop sample, rx_wr_o=1 if rx_full_i=0.
- Overrun:
  - If rx_full_i=1 at that cycle, the frame is discarded (no strobe) and an internal overrun_pend flag is set.
  - The next written frame carries bit 11=1, and overrun_pend clears on that write.
- After the frame: if the last sampled stop bit was 0, go to WAIT_HIGH, which stays until rx is sampled 1 on a tick and then goes to IDLE. Otherwise go directly to IDLE.
- rx_data_o holds the last written word until the next write.

## Timing
- Reset values:
  - State IDLE; counter 0; overrun_pend 0.
  - rx_wr_o=0, rx_data_o=12'h000, busy_o=0.
  - Synchronizer flops reset to 1 (idle line).
- Reset asserted mid-frame: everything above applies immediately. No write is issued and the partial frame is lost.
- Input latency: 2 clk_i synchronizer cycles before rx_i is visible to the FSM.
- Detection delay: the start edge is seen on the first tick with the synchronized rx low, which is up to 1 tick late.
- Frame latency: from start detection to the final stop sample is OVS/2 + (N + P + S)·OVS ticks, where P∈{0,1} and S∈{1,2}. rx_wr_o follows exactly 1 clk_i later.
- rx_data_o becomes valid in the same cycle as rx_wr_o.
- Simultaneous events: if a start is detected on the same tick that the final stop sample leaves STOP, that start is not taken; detection resumes on the next tick in IDLE.

## Configuration
- UART_RX_PARITY_EN defined:
  - The PARITY state is implemented.
  - parity_en_i and parity_odd_i behave as described above.
- UART_RX_PARITY_EN undefined:
  - The PARITY state and parity logic are removed.
  - parity_en_i and parity_odd_i remain as ports but are ignored.
  - rx_data_o[8] is constant 0.
  - Break detection considers data bits only.

## Test plan
- 8N1, send 0xA5 at OVS=16 → exactly one rx_wr_o; rx_data_o=12'h0A5; busy_o falls after the stop bit.
- 7 data bits, even parity (macro on), send 0x41 with a wrong parity bit → rx_data_o=12'h141.
- 8N1, 0x3C with the stop bit held 0 for one bit time, then high → rx_data_o=12'h23C; WAIT_HIGH is entered, then IDLE.
- Line held low for 2 frame times → rx_data_o=12'h600 (break plus framing error); no second write until rx returns high.
- Low glitch of 4 ticks on an idle line → no write, FSM back in IDLE. Separately: rx_full_i=1 during frame 0x11, then frame 0x22 with rx_full_i=0 → only one write, rx_data_o=12'h822.
- Assert rst_ni low in the middle of the DATA state → outputs return to reset values; the next clean frame 0x5A yields 12'h05A.
